// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and helpers for the alarm comparator/sequencer.
// Build option: ALARM_SNOOZE_EN enables the snooze path in alarm_unit.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // Counter only has to reach secs-1, so clog2(secs) bits suffice (min 1).
  function automatic int ring_cnt_width(input int secs);
    return (secs <= 2) ? 1 : $clog2(secs);
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Combinational hh:mm + N minutes in packed BCD, wrapping 59->00 minutes
// (carry into hours) and 23->00 hours.
module bcd_time_add
  import alarm_pkg::*;
(
  input  logic [7:0] in_hr,
  input  logic [7:0] in_min,
  input  logic [5:0] add_min,
  output logic [7:0] out_hr,
  output logic [7:0] out_min
);

  localparam logic [7:0] MIN_LIMIT = 8'(bcd_to_bin(MIN_MAX)) + 8'd1;
  localparam logic [7:0] HR_LIMIT  = 8'(bcd_to_bin(HR_MAX)) + 8'd1;

  logic [7:0] min_bin;
  logic [7:0] hr_bin;
  logic       carry;

  always_comb begin
    min_bin = {1'b0, bcd_to_bin(in_min)} + {2'b00, add_min};
    carry   = 1'b0;
    if (min_bin >= MIN_LIMIT) begin
      min_bin = min_bin - MIN_LIMIT;
      carry   = 1'b1;
    end
    hr_bin = {1'b0, bcd_to_bin(in_hr)} + {7'd0, carry};
    if (hr_bin >= HR_LIMIT) begin
      hr_bin = hr_bin - HR_LIMIT;
    end
    out_min = bin_to_bcd(min_bin[6:0]);
    out_hr  = bin_to_bcd(hr_bin[6:0]);
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm comparator/sequencer: fires on the rising edge of hr:min == alarm time
// and holds alert for RING_SECS ticks. Build option: ALARM_SNOOZE_EN.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       sec_clk,
  input  logic       reset,
  input  logic       enablealarm,
  input  logic [7:0] alarmmin,
  input  logic [7:0] alarmhr,
  input  logic [7:0] min,
  input  logic [7:0] hr,
  input  logic       dismiss,
`ifdef ALARM_SNOOZE_EN
  input  logic       snooze,
`endif
  output logic       alert
);

  if (RING_SECS < 1 || RING_SECS > 255 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_param
    $error("alarm_unit: RING_SECS or SNOOZE_MIN out of range");
  end

  localparam int                CNT_W    = ring_cnt_width(RING_SECS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RING_SECS - 1);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alert_q, alert_d;
  logic             match_q, match_d;
  logic             match;
  logic             fire;
  logic             snooze_req;
  logic             target_hit;
  logic             load_tgt;

  assign match   = (min == alarmmin) && (hr == alarmhr);
  assign match_d = match;
  assign fire    = match && !match_q;

`ifdef ALARM_SNOOZE_EN
  logic [7:0] tgt_hr_q, tgt_hr_d;
  logic [7:0] tgt_min_q, tgt_min_d;
  logic [7:0] snz_hr, snz_min;

  bcd_time_add u_snooze_add (
    .in_hr   (hr),
    .in_min  (min),
    .add_min (6'(SNOOZE_MIN)),
    .out_hr  (snz_hr),
    .out_min (snz_min)
  );

  assign snooze_req = snooze;
  // Snooze wake-up is a level compare: the first tick at the target re-rings.
  assign target_hit = (hr == tgt_hr_q) && (min == tgt_min_q);
  assign tgt_hr_d   = load_tgt ? snz_hr  : tgt_hr_q;
  assign tgt_min_d  = load_tgt ? snz_min : tgt_min_q;
`else
  assign snooze_req = 1'b0;
  assign target_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alert_d  = 1'b0;
    load_tgt = 1'b0;
    if (!enablealarm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire && !dismiss) begin
            state_d = RINGING;
            cnt_d   = '0;
            alert_d = 1'b1;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_d = IDLE;
          end else if (snooze_req) begin
            state_d  = SNOOZED;
            load_tgt = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            alert_d = 1'b1;
          end
        end
        SNOOZED: begin
          if (dismiss) begin
            state_d = IDLE;
          end else if (target_hit) begin
            state_d = RINGING;
            cnt_d   = '0;
            alert_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sec_clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alert_q   <= 1'b0;
      match_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      tgt_hr_q  <= 8'h00;
      tgt_min_q <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alert_q   <= alert_d;
      match_q   <= match_d;
`ifdef ALARM_SNOOZE_EN
      tgt_hr_q  <= tgt_hr_d;
      tgt_min_q <= tgt_min_d;
`endif
    end
  end

  assign alert = alert_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit and bcd_time_add.
// Snooze scenario is compiled in when ALARM_SNOOZE_EN is defined.
module tb_alarm_unit;

  localparam int RING = 60;
  localparam int SNZ  = 5;

  logic       sec_clk = 1'b0;
  logic       reset;
  logic       enablealarm;
  logic [7:0] alarmmin, alarmhr, t_min, t_hr;
  logic       dismiss;
  logic       snooze;
  logic       alert;

  logic [7:0] a_hr, a_min, r_hr, r_min;
  logic [5:0] a_add;

  int checks = 0;
  int errors = 0;

  always #5 sec_clk = ~sec_clk;

  alarm_unit #(.RING_SECS(RING), .SNOOZE_MIN(SNZ)) dut (
    .sec_clk     (sec_clk),
    .reset       (reset),
    .enablealarm (enablealarm),
    .alarmmin    (alarmmin),
    .alarmhr     (alarmhr),
    .min         (t_min),
    .hr          (t_hr),
    .dismiss     (dismiss),
`ifdef ALARM_SNOOZE_EN
    .snooze      (snooze),
`endif
    .alert       (alert)
  );

  bcd_time_add u_add (
    .in_hr   (a_hr),
    .in_min  (a_min),
    .add_min (a_add),
    .out_hr  (r_hr),
    .out_min (r_min)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge sec_clk);
    #1;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m);
    t_hr  = h;
    t_min = m;
  endtask

  task automatic add_case(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [5:0] n, input logic [15:0] exp);
    a_hr  = h;
    a_min = m;
    a_add = n;
    #1;
    check(tag, {16'd0, r_hr, r_min}, {16'd0, exp});
  endtask

  initial begin
    reset = 1'b0; enablealarm = 1'b1; dismiss = 1'b0; snooze = 1'b0;
    alarmhr = 8'h00; alarmmin = 8'h01;
    set_time(8'h00, 8'h00);
    a_hr = 8'h00; a_min = 8'h00; a_add = 6'd0;

    // Reset, then a full 60-tick ring and auto-timeout
    tick();
    check("reset_alert", alert, 1'b0);
    reset = 1'b1;
    tick();
    check("idle_nomatch", alert, 1'b0);
    set_time(8'h00, 8'h01);
    tick();
    check("fire_latency", alert, 1'b1);
    for (int i = 1; i < RING; i++) begin
      tick();
      check($sformatf("ring_%0d", i), alert, 1'b1);
    end
    tick();
    check("timeout", alert, 1'b0);
    tick();
    check("no_refire_timeout", alert, 1'b0);

    // Match while disabled; enabling mid-minute must not fire
    set_time(8'h00, 8'h00);
    tick();
    enablealarm = 1'b0;
    set_time(8'h00, 8'h01);
    tick();
    check("disabled_match", alert, 1'b0);
    enablealarm = 1'b1;
    tick();
    check("enable_mid_minute", alert, 1'b0);

    // 07:30 ring dismissed at cycle 10, no re-fire, fires next day
    alarmhr = 8'h07; alarmmin = 8'h30;
    set_time(8'h07, 8'h29);
    tick();
    set_time(8'h07, 8'h30);
    tick();
    check("fire_0730", alert, 1'b1);
    for (int i = 1; i < 10; i++) tick();
    check("ring_cycle9", alert, 1'b1);
    dismiss = 1'b1;
    tick();
    check("dismiss", alert, 1'b0);
    dismiss = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check($sformatf("after_dismiss_%0d", i), alert, 1'b0);
    end
    set_time(8'h07, 8'h31);
    tick();
    set_time(8'h07, 8'h30);
    tick();
    check("next_day_fire", alert, 1'b1);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    check("dismiss2", alert, 1'b0);

    // Match edge together with dismiss is swallowed
    set_time(8'h07, 8'h31);
    tick();
    set_time(8'h07, 8'h30);
    dismiss = 1'b1;
    tick();
    check("edge_with_dismiss", alert, 1'b0);
    dismiss = 1'b0;
    tick();
    check("edge_with_dismiss_after", alert, 1'b0);

    // Reset during ringing; match on first cycle after reset fires
    set_time(8'h07, 8'h31);
    tick();
    set_time(8'h07, 8'h30);
    tick();
    check("fire_before_reset", alert, 1'b1);
    reset = 1'b0;
    tick();
    check("reset_in_ringing", alert, 1'b0);
    reset = 1'b1;
    tick();
    check("first_cycle_after_reset", alert, 1'b1);
    enablealarm = 1'b0;
    tick();
    check("disable_in_ringing", alert, 1'b0);
    enablealarm = 1'b1;

    // Alarm-time change creates a new match edge
    set_time(8'h08, 8'h00);
    tick();
    check("no_match_0800", alert, 1'b0);
    alarmhr = 8'h08; alarmmin = 8'h00;
    tick();
    check("alarm_change_fire", alert, 1'b1);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    check("dismiss3", alert, 1'b0);

`ifdef ALARM_SNOOZE_EN
    // Snooze at 23:58 re-rings at 00:03 across the day wrap
    alarmhr = 8'h23; alarmmin = 8'h58;
    set_time(8'h23, 8'h57);
    tick();
    set_time(8'h23, 8'h58);
    tick();
    check("snz_fire", alert, 1'b1);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check("snz_enter", alert, 1'b0);
    set_time(8'h23, 8'h59);
    tick();
    check("snz_2359", alert, 1'b0);
    for (int m = 0; m < 3; m++) begin
      set_time(8'h00, 8'(m));
      tick();
      check($sformatf("snz_000%0d", m), alert, 1'b0);
    end
    set_time(8'h00, 8'h03);
    tick();
    check("snz_rering", alert, 1'b1);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    check("snz_dismiss", alert, 1'b0);
`endif

    // Stand-alone BCD adder cases
    add_case("add_0959_5", 8'h09, 8'h59, 6'd5, 16'h1004);
    add_case("add_2357_5", 8'h23, 8'h57, 6'd5, 16'h0002);
    add_case("add_1200_59", 8'h12, 8'h00, 6'd59, 16'h1259);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
